// File: rtl/lane_striper_n.sv
// Stripes a serial symbol stream across up to NLANES lanes, one group per output beat; flush pads a partial group.
// Latency: a completed group appears on out/validout one edge later. Backpressure: ready drops only while a finished group waits in STALL.
module lane_striper_n #(
  parameter int             NLANES = 4,
  parameter int             DW     = 8,
  parameter logic [DW-1:0]  PAD    = DW'(8'hBC)
) (
  input  logic                   clk4f,
  input  logic                   reset,
  input  logic [DW-1:0]          in,
  input  logic                   validin,
  output logic                   ready,
  input  logic                   flush,
  input  logic [1:0]             lane_mode,
  output logic [NLANES*DW-1:0]   out,
  output logic [NLANES-1:0]      validout,
  input  logic                   out_ready
);

  localparam int PW = $clog2(NLANES) + 1;

  typedef enum logic [1:0] {EMPTY, FILL, STALL} state_t;

  state_t                 state;
  logic [PW-1:0]          ptr;
  logic [PW-1:0]          grp_l;
  logic [NLANES*DW-1:0]   acc;
  logic [NLANES-1:0]      stall_msk;

  int                     sel_n;
  logic [PW-1:0]          sel_l;
  logic [PW-1:0]          cur_l;
  logic [PW-1:0]          ptr_nxt;
  logic                   fire;
  logic                   done;
  logic [NLANES*DW-1:0]   grp_dat;
  logic [NLANES-1:0]      grp_msk;

  assign ready = (state != STALL);
  assign fire  = validin & ready;

  always_comb begin
    unique case (lane_mode)
      2'd0:    sel_n = 1;
      2'd1:    sel_n = 2;
      2'd2:    sel_n = 4;
      default: sel_n = 8;
    endcase
    if (sel_n > NLANES) sel_n = NLANES;
    sel_l = PW'(sel_n);
  end

  // The lane count is taken live only for the first symbol of a group.
  assign cur_l   = (ptr == '0) ? sel_l : grp_l;
  assign ptr_nxt = ptr + PW'(fire);
  assign done    = ready & ((fire & (ptr_nxt == cur_l)) | (flush & (ptr_nxt != '0)));

  // Group as it would leave this cycle: same-cycle symbol merged, tail padded, inactive lanes zeroed.
  always_comb begin
    grp_dat = '0;
    grp_msk = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (PW'(i) < cur_l) begin
        grp_msk[i] = 1'b1;
        if (fire && (PW'(i) == ptr))
          grp_dat[i*DW +: DW] = in;
        else if (PW'(i) < ptr)
          grp_dat[i*DW +: DW] = acc[i*DW +: DW];
        else
          grp_dat[i*DW +: DW] = PAD;
      end
    end
  end

  always_ff @(posedge clk4f or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      ptr       <= '0;
      grp_l     <= '0;
      acc       <= '0;
      stall_msk <= '0;
      out       <= '0;
      validout  <= '0;
    end else begin
      unique case (state)
        EMPTY, FILL: begin
          if (done) begin
            ptr <= '0;
            if ((validout == '0) || out_ready) begin
              out      <= grp_dat;
              validout <= grp_msk;
              state    <= EMPTY;
            end else begin
              acc       <= grp_dat;
              stall_msk <= grp_msk;
              state     <= STALL;
            end
          end else begin
            if (out_ready) validout <= '0;
            if (fire) begin
              for (int i = 0; i < NLANES; i++)
                if (PW'(i) == ptr) acc[i*DW +: DW] <= in;
              if (ptr == '0) grp_l <= sel_l;
              ptr   <= ptr_nxt;
              state <= FILL;
            end
          end
        end
        STALL: begin
          if (out_ready) begin
            out      <= acc;
            validout <= stall_msk;
            state    <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_striper_n.sv
// Bench for lane_striper_n (NLANES=4, DW=8): directed scenarios plus random traffic against a queue-based model.
module tb_lane_striper_n;

  logic        clk4f = 1'b0;
  logic        reset;
  logic [7:0]  in;
  logic        validin;
  logic        ready;
  logic        flush;
  logic [1:0]  lane_mode;
  logic [31:0] out;
  logic [3:0]  validout;
  logic        out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: symbols of the open group, its lane count, the presented beat and a parked beat.
  logic [7:0]  q[$];
  int          m_l;
  logic        m_stalled;
  logic [31:0] m_out, m_stall_w;
  logic [3:0]  m_outv, m_stall_m;

  lane_striper_n #(.NLANES(4), .DW(8), .PAD(8'hBC)) dut (
    .clk4f(clk4f), .reset(reset), .in(in), .validin(validin), .ready(ready),
    .flush(flush), .lane_mode(lane_mode), .out(out), .validout(validout),
    .out_ready(out_ready)
  );

  always #5 clk4f = ~clk4f;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_l       = 1;
    m_stalled = 1'b0;
    m_out     = '0;
    m_outv    = '0;
    m_stall_w = '0;
    m_stall_m = '0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d, input logic f,
                            input logic [1:0] m, input logic ordy);
    logic        acc_ok;
    logic        complete;
    logic [31:0] w;
    logic [3:0]  msk;
    int          lanes;
    acc_ok = v && !m_stalled;
    if (acc_ok) begin
      if (q.size() == 0) begin
        lanes = 1 << m;
        m_l = (lanes > 4) ? 4 : lanes;
      end
      q.push_back(d);
    end
    complete = (acc_ok && q.size() == m_l) || (f && !m_stalled && q.size() > 0);
    if (complete) begin
      w = '0;
      for (int i = 0; i < 4; i++) begin
        if (i < q.size())  w[i*8 +: 8] = q[i];
        else if (i < m_l)  w[i*8 +: 8] = 8'hBC;
      end
      msk = 4'((1 << m_l) - 1);
      q.delete();
      if (m_outv == 0 || ordy) begin
        m_out  = w;
        m_outv = msk;
      end else begin
        m_stalled = 1'b1;
        m_stall_w = w;
        m_stall_m = msk;
      end
    end else if (m_stalled && ordy) begin
      m_out     = m_stall_w;
      m_outv    = m_stall_m;
      m_stalled = 1'b0;
    end else if (ordy) begin
      m_outv = '0;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic v, input logic [7:0] d, input logic f,
                      input logic [1:0] m, input logic ordy);
    validin   = v;
    in        = d;
    flush     = f;
    lane_mode = m;
    out_ready = ordy;
    #1;
    chk("ready", ready, !m_stalled);
    model_edge(v, d, f, m, ordy);
    @(posedge clk4f);
    #1;
    chk("validout", validout, m_outv);
    if (m_outv != 0) chk("out", out, m_out);
    chk("ready_post", ready, !m_stalled);
    @(negedge clk4f);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_out", out, 32'h0);
    chk("rst_validout", validout, 4'h0);
    chk("rst_ready", ready, 1'b1);
    @(negedge clk4f);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; in = '0; validin = 1'b0; flush = 1'b0; lane_mode = 2'd2; out_ready = 1'b1;
    model_reset();
    @(negedge clk4f);
    @(negedge clk4f);
    do_reset();

    // Full x4 group, then a single valid beat.
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 2'd2, 1);
    chk("x4_grp", out, 32'h04030201);
    chk("x4_msk", validout, 4'hF);
    step(0, 0, 0, 2'd2, 1);
    chk("x4_clear", validout, 4'h0);

    // x2 with a flushed tail.
    step(1, 8'hAA, 0, 2'd1, 1);
    step(1, 8'hBB, 0, 2'd1, 1);
    chk("x2_grp0", out, 32'h0000BBAA);
    chk("x2_msk0", validout, 4'h3);
    step(1, 8'hCC, 0, 2'd1, 1);
    step(0, 0, 1, 2'd1, 1);
    chk("x2_grp1", out, 32'h0000BCCC);
    chk("x2_msk1", validout, 4'h3);
    step(0, 0, 0, 2'd1, 1);

    // Backpressure: second group parks until out_ready.
    for (int i = 0; i < 8; i++) step(1, 8'(8'h10 + i), 0, 2'd2, 0);
    chk("stall_held", out, 32'h13121110);
    chk("stall_rdy", ready, 1'b0);
    step(0, 0, 0, 2'd2, 1);
    chk("stall_rel", out, 32'h17161514);
    chk("stall_rdy1", ready, 1'b1);
    step(0, 0, 0, 2'd2, 1);

    // Reset mid-fill discards the partial group.
    step(1, 8'h55, 0, 2'd2, 1);
    step(1, 8'h66, 0, 2'd2, 1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'(8'h20 + i), 0, 2'd2, 1);
    chk("post_rst", out, 32'h23222120);
    step(0, 0, 0, 2'd2, 1);

    // Lane-mode change mid-group takes effect only for the next group.
    step(1, 8'hA0, 0, 2'd2, 1);
    step(1, 8'hA1, 0, 2'd2, 1);
    step(1, 8'hA2, 0, 2'd0, 1);
    step(1, 8'hA3, 0, 2'd0, 1);
    chk("mode_old", validout, 4'hF);
    chk("mode_old_dat", out, 32'hA3A2A1A0);
    step(1, 8'hA4, 0, 2'd0, 1);
    chk("mode_new", validout, 4'h1);
    chk("mode_new_dat", out, 32'h000000A4);
    step(0, 0, 0, 2'd0, 1);

    // Flush with nothing pending, and flush while stalled.
    step(0, 0, 1, 2'd2, 1);
    chk("flush_empty", validout, 4'h0);
    step(1, 8'hB0, 0, 2'd0, 0);
    step(1, 8'hB1, 0, 2'd0, 0);
    step(0, 0, 1, 2'd0, 0);
    chk("flush_stall_rdy", ready, 1'b0);
    chk("flush_stall_out", out, 32'h000000B0);
    step(0, 0, 0, 2'd0, 1);
    chk("flush_stall_rel", out, 32'h000000B1);
    step(0, 0, 0, 2'd0, 1);

    // Reset while stalled discards the parked group.
    step(1, 8'hC0, 0, 2'd0, 0);
    step(1, 8'hC1, 0, 2'd0, 0);
    do_reset();
    step(0, 0, 0, 2'd0, 1);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 7) == 0),
             2'($urandom), 1'($urandom_range(0, 2) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_striper_n.md
LANE_STRIPER_N -- requirements
Module: lane_striper_n

Interface
REQ-001 SHALL have parameter NLANES, default 4, meaning maximum lane count, legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter DW, default 8, meaning symbol width in bits per lane.
REQ-003 SHALL have parameter PAD, default 8'hBC (DW bits), meaning the symbol inserted into unfilled lanes on flush.
REQ-004 SHALL have port clk4f  input  1  meaning the single clock, rising-edge.
REQ-005 SHALL have port reset  input  1  meaning reset, asynchronous, active-low.
REQ-006 SHALL have port in  input  DW  meaning the serial symbol stream.
REQ-007 SHALL have port validin  input  1  meaning `in` carries a symbol this cycle.
REQ-008 SHALL have port ready  output  1  meaning the block accepts `in` this cycle.
REQ-009 SHALL have port flush  input  1  meaning close the partial group with PAD.
REQ-010 SHALL have port lane_mode  input  2  meaning active width: 00=x1, 01=x2, 10=x4, 11=x8.
REQ-011 SHALL have port out  output  NLANES*DW  meaning lane i is at bits [i*DW +: DW].
REQ-012 SHALL have port validout  output  NLANES  meaning the active-lane mask of the presented group.
REQ-013 SHALL have port out_ready  input  1  meaning the downstream consumes the presented group.

Function
REQ-014 SHALL compute active lanes L = min(2^lane_mode, NLANES).
REQ-015 SHALL accept a symbol when validin=1 and ready=1, writing it to accumulator lane ptr and incrementing ptr.
REQ-016 SHALL latch L when the first symbol of a group is accepted (ptr=0), and ignore lane_mode changes until that group completes.
REQ-017 SHALL use FSM states EMPTY (ptr=0), FILL (0<ptr<L) and STALL (group complete, output register occupied).
REQ-018 SHALL treat as group-complete either acceptance with ptr=L-1, or flush=1 with ptr>0 (after any same-cycle acceptance).
REQ-019 SHALL, on group-complete: when the output register is empty or out_ready=1, load out/validout at that edge and return to EMPTY; otherwise enter STALL.
REQ-020 SHALL drive ready=1 in EMPTY and FILL and ready=0 in STALL (combinational from state only).
REQ-021 SHALL, in STALL, move the accumulator to the output at the first edge with out_ready=1 and go to EMPTY.
REQ-022 SHALL fill lanes ptr..L-1 with PAD on flush; validout SHALL be the low L bits set, including padded lanes.
REQ-023 SHALL hold lanes >= L at 0 with their validout bits at 0.
REQ-024 SHALL hold out and validout stable while validout!=0 and out_ready=0.
REQ-025 SHALL clear validout at an edge with out_ready=1 when no new group loads at that edge.
REQ-026 SHALL have latency of one edge: a group completed in cycle k is visible in cycle k+1 when not stalled.
REQ-027 SHALL treat flush with ptr=0 as a no-op, and ignore flush in STALL.
REQ-028 SHALL wrap ptr to 0 after lane L-1; ptr width SHALL be clog2(NLANES)+1.

Reset
REQ-029 SHALL, on reset low, immediately clear out to 0, validout to 0, ptr to 0 and the accumulator to 0, and set the FSM to EMPTY (ready=1).
REQ-030 SHALL discard a partial group on reset mid-FILL, and discard a stalled group on reset in STALL.
REQ-031 SHALL leave reset deassertion synchronous to clk4f by the system; the first acceptance SHALL be possible on the first edge with reset high.

Verification (NLANES=4, DW=8)
REQ-032 SHALL cover: x4, out_ready=1, in=01,02,03,04 on consecutive cycles -> next cycle out={04,03,02,01}, validout=4'b1111 for one cycle.
REQ-033 SHALL cover: x2, in=AA,BB,CC then flush -> group {BB,AA} with validout=0011, then {BC,CC} with validout=0011.
REQ-034 SHALL cover: x4, out_ready=0, 8 symbols 10..17 -> group {13..10} held, ready=0 after 17 accepted; out_ready=1 -> {17..14} next cycle, then ready=1.
REQ-035 SHALL cover: reset low after 2 accepted symbols -> out=0, validout=0, ready=1; then 20,21,22,23 -> {23,22,21,20}, with no stale data.
REQ-036 SHALL cover: x4 to x1 switch after 2 symbols -> that group completes as x4 (validout=1111); subsequent symbols each present with validout=0001.
REQ-037 SHALL cover: flush with ptr=0, and flush in STALL -> no new group and no state change.
